// File: rtl/rgb565_to_axis.sv
// RGB565 video to AXI4-Stream bridge with frame-aligned FWFT buffering.
// Expands pixels to 24-bit RBG, tags start-of-frame and end-of-line.
module rgb565_to_axis #(
  parameter int H_ACTIVE   = 640,
  parameter int FIFO_DEPTH = 16,
  parameter bit VS_POL     = 1'b0
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        de,
  input  logic        vs,
  input  logic [4:0]  red,
  input  logic [5:0]  green,
  input  logic [4:0]  blue,
  output logic [23:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic        overflow,
  output logic        len_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(H_ACTIVE + 1);
  localparam logic [CW-1:0] HLEN = CW'(H_ACTIVE);

  typedef enum logic [1:0] {
    SYNC,
    ARMED,
    STREAM
  } state_t;

  state_t state;

  logic          de_d;
  logic          vs_d;
  logic          in_valid;
  logic [15:0]   pix_d;
  logic          vs_seen;
  logic [CW-1:0] cnt;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [25:0]   mem [FIFO_DEPTH];

  logic [4:0]    r5;
  logic [5:0]    g6;
  logic [4:0]    b5;
  logic [23:0]   pix24;
  logic          vs_act;
  logic          last_w;
  logic          full;
  logic          empty;
  logic          pop;
  logic          accept;
  logic          push;
  logic          drop;
  logic [25:0]   head;

  assign r5     = pix_d[15:11];
  assign g6     = pix_d[10:5];
  assign b5     = pix_d[4:0];
  assign pix24  = {r5, r5[4:2], b5, b5[4:2], g6, g6[5:4]};

  // Input regs hold reset values for one cycle; ignore vs_d until a real sample.
  assign vs_act = in_valid & (vs_d == VS_POL);
  assign last_w = ~de;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop    = ~empty & m_axis_tready;
  assign accept = de_d & (state != SYNC);
  assign push   = accept & (~full | pop);
  assign drop   = accept & full & ~pop;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      de_d     <= 1'b0;
      vs_d     <= 1'b0;
      pix_d    <= '0;
      in_valid <= 1'b0;
    end else begin
      de_d     <= de;
      vs_d     <= vs;
      pix_d    <= {red, green, blue};
      in_valid <= 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= SYNC;
      vs_seen <= 1'b0;
    end else if (vs_act) begin
      state   <= SYNC;
      vs_seen <= 1'b1;
    end else begin
      unique case (state)
        SYNC: begin
          if (vs_seen) begin
            state   <= ARMED;
            vs_seen <= 1'b0;
          end
        end
        ARMED: begin
          if (drop)
            state <= SYNC;
          else if (push)
            state <= STREAM;
        end
        STREAM: begin
          if (drop)
            state <= SYNC;
        end
        default: state <= SYNC;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt      <= '0;
      len_err  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (vs_act || drop || (accept && last_w))
        cnt <= '0;
      else if (push && cnt != '1)
        cnt <= cnt + 1'b1;
      if (push && last_w && (cnt + 1'b1) != HLEN)
        len_err <= 1'b1;
      if (drop)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; outputs are masked while empty.
  always_ff @(posedge aclk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= {state == ARMED, last_w, pix24};
  end

  assign head          = mem[rd_ptr[AW-1:0]];
  assign m_axis_tvalid = ~empty;

  always_comb begin
    m_axis_tuser = 1'b0;
    m_axis_tlast = 1'b0;
    m_axis_tdata = '0;
    if (!empty)
      {m_axis_tuser, m_axis_tlast, m_axis_tdata} = head;
  end

endmodule
